// File: rtl/lsu_pkg.sv
//==============================================================================
// lsu_pkg: access-size encodings, FSM state type and alignment rule for the LSU
// Rev 1.0
//==============================================================================
`default_nettype none

package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic c_bad;
    c_bad = 1'b0;
    case (size)
      SZ_B:    c_bad = 1'b0;
      SZ_H:    c_bad = lane[0];
      SZ_W:    c_bad = (lane != 2'b00);
      default: c_bad = 1'b1;
    endcase
    return c_bad;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
//==============================================================================
// lsu_align: load lane extraction/extension and store byte-lane merging
// Rev 1.0
//==============================================================================
`default_nettype none

module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  lane,
  input  logic [31:0] rd_word,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [31:0] w_byte_sh;
  logic [31:0] w_half_sh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [3:0]  w_be;
  logic [31:0] w_rep;

  assign w_byte_sh = rd_word >> {lane, 3'b000};
  assign w_half_sh = rd_word >> {lane[1], 4'b0000};
  assign w_byte    = w_byte_sh[7:0];
  assign w_half    = w_half_sh[15:0];

  always_comb begin
    load_data = rd_word;
    case (size)
      SZ_B:    load_data = {{24{sign_ext & w_byte[7]}}, w_byte};
      SZ_H:    load_data = {{16{sign_ext & w_half[15]}}, w_half};
      default: load_data = rd_word;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    w_be  = 4'b1111;
    w_rep = wdata;
    case (size)
      SZ_B: begin
        w_be  = 4'b0001 << lane;
        w_rep = {4{wdata[7:0]}};
      end
      SZ_H: begin
        w_be  = 4'b0011 << {lane[1], 1'b0};
        w_rep = {2{wdata[15:0]}};
      end
      default: begin
        w_be  = 4'b1111;
        w_rep = wdata;
      end
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign store_word[8*i +: 8] = w_be[i] ? w_rep[8*i +: 8] : old_word[8*i +: 8];
  end

endmodule

`default_nettype wire

// File: rtl/lsu.sv
//==============================================================================
// lsu: multi-cycle load/store unit (read-modify-write stores) for a 1 KiB memory
// Rev 1.0
//==============================================================================
`default_nettype none

module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic        misalign,
  output logic [31:0] rdata,
  output logic [9:0]  dm_addr,
  output logic [31:0] dm_din,
  output logic        dm_wr,
  input  logic [31:0] dm_dout
);

  state_t      r_state;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_sext;
  logic [9:0]  r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_buf;
  logic [31:0] r_rdata;
  logic        r_ack;
  logic        r_mis;

  logic [31:0] w_load;
  logic [31:0] w_store;
  logic        w_unused_addr;

  // Upper address bits alias onto the 1 KiB window.
  assign w_unused_addr = &{1'b0, addr[31:10]};

  lsu_align u_align (
    .size       (r_size),
    .sign_ext   (r_sext),
    .lane       (r_addr[1:0]),
    .rd_word    (dm_dout),
    .old_word   (r_buf),
    .wdata      (r_wdata),
    .load_data  (w_load),
    .store_word (w_store)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_size  <= SZ_B;
      r_sext  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_buf   <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_mis <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_we    <= we;
            r_size  <= size;
            r_sext  <= sign_ext;
            r_addr  <= addr[9:0];
            r_wdata <= wdata;
            if (is_misaligned(size, addr[1:0])) begin
              r_state <= ST_ERR;
              r_ack   <= 1'b1;
              r_mis   <= 1'b1;
            end else begin
              r_state <= ST_RD;
            end
          end
        end
        ST_RD: begin
          r_buf <= dm_dout;
          if (r_we) begin
            r_state <= ST_WR;
          end else begin
            r_rdata <= w_load;
            r_ack   <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_WR: begin
          r_ack   <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE, ST_ERR: r_state <= ST_IDLE;
        default:         r_state <= ST_IDLE;
      endcase
    end
  end

  assign ack      = r_ack;
  assign misalign = r_mis;
  assign rdata    = r_rdata;
  assign dm_addr  = {r_addr[9:2], 2'b00};
  assign dm_din   = w_store;
  assign dm_wr    = (r_state == ST_WR);

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
//==============================================================================
// tb_lsu: directed and random load/store traffic against a byte-array memory model
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        ack;
  logic        misalign;
  logic [31:0] rdata;
  logic [9:0]  dm_addr;
  logic [31:0] dm_din;
  logic        dm_wr;
  logic [31:0] dm_dout;

  lsu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .we       (we),
    .size     (size),
    .sign_ext (sign_ext),
    .addr     (addr),
    .wdata    (wdata),
    .ack      (ack),
    .misalign (misalign),
    .rdata    (rdata),
    .dm_addr  (dm_addr),
    .dm_din   (dm_din),
    .dm_wr    (dm_wr),
    .dm_dout  (dm_dout)
  );

  always #5 clk = ~clk;

  bit [31:0] mem [0:255];
  always @(posedge clk) if (dm_wr) mem[dm_addr[9:2]] <= dm_din;
  assign dm_dout = mem[dm_addr[9:2]];

  bit [7:0] ref_mem [0:1023];

  int checks = 0;
  int failures = 0;

  logic        exp_ack = 1'b0;
  logic        exp_mis = 1'b0;
  logic        exp_wr = 1'b0;
  logic [31:0] exp_rdata = '0;
  logic        addr_chk = 1'b0;
  logic [9:0]  exp_dmaddr = '0;
  logic [31:0] exp_din = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("ack", {31'b0, ack}, {31'b0, exp_ack});
    chk("misalign", {31'b0, misalign}, {31'b0, exp_mis});
    chk("dm_wr", {31'b0, dm_wr}, {31'b0, exp_wr});
    chk("rdata", rdata, exp_rdata);
    if (addr_chk) chk("dm_addr", {22'b0, dm_addr}, {22'b0, exp_dmaddr});
    if (exp_wr) chk("dm_din", dm_din, exp_din);
  end

  function automatic logic [31:0] m_word(input logic [9:0] a);
    int b;
    b = int'({a[9:2], 2'b00});
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sx, input logic [9:0] a);
    int i;
    logic [7:0]  b;
    logic [15:0] h;
    i = int'(a);
    if (sz == 2'd0) begin
      b = ref_mem[i];
      return sx ? {{24{b[7]}}, b} : {24'b0, b};
    end else if (sz == 2'd1) begin
      h = {ref_mem[i+1], ref_mem[i]};
      return sx ? {{16{h[15]}}, h} : {16'b0, h};
    end
    return m_word(a);
  endfunction

  function automatic logic [31:0] m_store_word(input logic [1:0] sz, input logic [9:0] a, input logic [31:0] wd);
    logic [7:0] t [0:3];
    int b, o;
    b = int'({a[9:2], 2'b00});
    o = int'(a[1:0]);
    for (int k = 0; k < 4; k++) t[k] = ref_mem[b+k];
    if (sz == 2'd0) t[o] = wd[7:0];
    else if (sz == 2'd1) begin t[o] = wd[7:0]; t[o+1] = wd[15:8]; end
    else for (int k = 0; k < 4; k++) t[k] = wd[8*k +: 8];
    return {t[3], t[2], t[1], t[0]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    req = 1'b0; exp_ack = 1'b0; exp_mis = 1'b0; exp_wr = 1'b0; addr_chk = 1'b0;
  endtask

  // nz: 0 quiet, 1 random req/inputs while busy, 2 req held high while busy.
  task automatic do_op(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd, input int nz);
    logic        mis;
    int          lat;
    logic [9:0]  la;
    logic [31:0] lr, nw;
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
    exp_ack = 1'b0; exp_mis = 1'b0; exp_wr = 1'b0; addr_chk = 1'b0;
    cyc();
    la  = a[9:0];
    mis = (sz == 2'd3) || (sz == 2'd1 && la[0]) || (sz == 2'd2 && la[1:0] != 2'b00);
    lat = mis ? 1 : (w ? 3 : 2);
    lr  = mis ? 32'h0 : m_load(sz, sx, la);
    nw  = mis ? 32'h0 : m_store_word(sz, la, wd);
    for (int k = 1; k <= lat; k++) begin
      if (nz == 1) begin
        req = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
        size = 2'($urandom_range(0, 3)); addr = $urandom; wdata = $urandom;
      end else begin
        req = (nz == 2);
      end
      exp_ack = (k == lat);
      exp_mis = mis && (k == lat);
      exp_wr  = w && !mis && (k == 2);
      addr_chk = 1'b1;
      exp_dmaddr = {la[9:2], 2'b00};
      exp_din = nw;
      if (!w && !mis && k == lat) exp_rdata = lr;
      cyc();
    end
    if (w && !mis) begin
      for (int k = 0; k < 4; k++) ref_mem[int'({la[9:2], 2'b00}) + k] = nw[8*k +: 8];
    end
    set_idle();
  endtask

  task automatic store_reset_in_wr(input logic [31:0] a, input logic [31:0] wd);
    logic [9:0] la;
    la = a[9:0];
    req = 1'b1; we = 1'b1; size = 2'd2; sign_ext = 1'b0; addr = a; wdata = wd;
    cyc();
    req = 1'b0; addr_chk = 1'b1; exp_dmaddr = {la[9:2], 2'b00};
    cyc();
    exp_wr = 1'b1; exp_din = wd;
    #2;
    chk("wr_before_reset", {31'b0, dm_wr}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("wr_async_drop", {31'b0, dm_wr}, 32'd0);
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_dm_addr", {22'b0, dm_addr}, 32'd0);
    exp_rdata = '0;
    set_idle();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    logic [31:0] r;
    cyc(); cyc();
    chk("reset_ack", {31'b0, ack}, 32'd0);
    chk("reset_misalign", {31'b0, misalign}, 32'd0);
    chk("reset_dm_wr", {31'b0, dm_wr}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_dm_addr", {22'b0, dm_addr}, 32'd0);
    rst_n = 1'b1;
    cyc();

    do_op(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEADBEEF, 0);
    do_op(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 0);
    chk("lw_010", rdata, 32'hDEADBEEF);

    do_op(1'b1, 2'd0, 1'b0, 32'h0000_0012, 32'h0000_0055, 0);
    chk("mem_010", mem[4], 32'hDE55BEEF);
    do_op(1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'h0, 0);
    chk("lb_013", rdata, 32'hFFFFFFDE);
    do_op(1'b0, 2'd0, 1'b0, 32'h0000_0012, 32'h0, 0);
    chk("lbu_012", rdata, 32'h00000055);

    do_op(1'b1, 2'd1, 1'b0, 32'h0000_0016, 32'h0000_8001, 0);
    do_op(1'b0, 2'd1, 1'b1, 32'h0000_0016, 32'h0, 0);
    chk("lh_016", rdata, 32'hFFFF8001);
    do_op(1'b0, 2'd1, 1'b0, 32'h0000_0016, 32'h0, 0);
    chk("lhu_016", rdata, 32'h00008001);
    do_op(1'b0, 2'd0, 1'b0, 32'h0000_0014, 32'h0, 0);
    chk("lbu_014", rdata, 32'h0);
    do_op(1'b0, 2'd0, 1'b0, 32'h0000_0015, 32'h0, 0);
    chk("lbu_015", rdata, 32'h0);

    do_op(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 0);
    do_op(1'b0, 2'd2, 1'b0, 32'h0000_0011, 32'h0, 0);
    do_op(1'b1, 2'd1, 1'b0, 32'h0000_0013, 32'h1234_5678, 0);
    do_op(1'b0, 2'd3, 1'b0, 32'h0000_0010, 32'h0, 0);
    do_op(1'b1, 2'd3, 1'b0, 32'h0000_0010, 32'hFFFF_FFFF, 0);
    chk("rdata_kept", rdata, 32'hDE55BEEF);
    chk("mem_010_kept", mem[4], 32'hDE55BEEF);

    do_op(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 2);
    do_op(1'b1, 2'd2, 1'b0, 32'hFFFF_F420, 32'hCAFEF00D, 2);
    do_op(1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0, 0);
    chk("wrap_020", rdata, 32'hCAFEF00D);

    store_reset_in_wr(32'h0000_0014, 32'h1234_5678);
    chk("abort_mem", mem[5], 32'h80010000);
    do_op(1'b0, 2'd2, 1'b0, 32'h0000_0014, 32'h0, 0);
    chk("abort_lw_014", rdata, 32'h80010000);

    for (int n = 0; n < 400; n++) begin
      r = $urandom;
      do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            {r[31:10], 4'b0000, r[5:0]}, $urandom, int'($urandom_range(0, 1)));
    end

    for (int w = 0; w < 256; w++) begin
      chk("mem_sweep", mem[w], m_word(10'(w * 4)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 req  in  1  access request from multi-cycle controller; sampled only in IDLE.
REQ-004 we  in  1  1 = store, 0 = load.
REQ-005 size  in  2  access width: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-006 sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-007 addr  in  32  byte address; only addr[9:0] used.
REQ-008 wdata  in  32  store data, right-justified for byte/halfword.
REQ-009 ack  out  1  one-cycle completion pulse.
REQ-010 misalign  out  1  asserted with ack when the access was rejected.
REQ-011 rdata  out  32  formatted load result; held until the next successful load completes.
REQ-012 dm_addr  out  10  word-aligned byte address to data memory: {addr[9:2],2'b00}.
REQ-013 dm_din  out  32  merged write word to data memory.
REQ-014 dm_wr  out  1  data-memory write enable; memory writes on the clk edge while high.
REQ-015 dm_dout  in  32  combinational read word from data memory, little-endian (byte at dm_addr is bits 7:0).

Function
REQ-016 FSM states: IDLE, RD, WR, DONE, ERR; reset state IDLE.
REQ-017 IDLE: on req=1, latch we, size, sign_ext, addr[9:0], wdata; go to ERR if misaligned, else RD.
REQ-018 Misaligned: size=01 with addr[0]=1; size=10 with addr[1:0]!=00; size=11 always.
REQ-019 RD: capture dm_dout into internal word buffer; load -> DONE with rdata updated; store -> WR.
REQ-020 Load format: byte lane addr[1:0], half lane addr[1]; extend to 32 bits per sign_ext; word passes unchanged.
REQ-021 WR: dm_wr=1, dm_din = buffer with selected byte/half lanes replaced by wdata low bits (word: wdata entire); next DONE.
REQ-022 DONE: ack=1, misalign=0 for one cycle; next IDLE.
REQ-023 ERR: ack=1, misalign=1 for one cycle; no dm_wr, rdata unchanged; next IDLE.
REQ-024 Latency from req-sampled edge: load ack in cycle +2, store ack in cycle +3, rejected ack in cycle +1.
REQ-025 req while not in IDLE is ignored; no queuing.
REQ-026 dm_wr decoded from state register only (glitch-free), high in WR only.
REQ-027 dm_addr driven from latched address in every non-IDLE state; don't-care-free: equals latched aligned address, 0 after reset.
REQ-028 Address wrap: addr[31:10] ignored; addr 0x400 aliases 0x000.

Reset
REQ-029 rst_n low forces immediately: state IDLE, ack 0, misalign 0, dm_wr 0, rdata 0, dm_addr 0, buffers 0.
REQ-030 Reset asserted in WR aborts the write (dm_wr drops asynchronously); partial transaction not resumed.

Structure
REQ-031 Package lsu_pkg holds size encodings (SZ_B, SZ_H, SZ_W) and the state enumeration.
REQ-032 Combinational sub-module lsu_align performs lane extraction/extension and store merging; lsu holds FSM and registers.

Verification
REQ-033 Store word 0xDEADBEEF at 0x010, then load word 0x010 -> dm_wr one cycle, ack at +3; load ack at +2, rdata=0xDEADBEEF.
REQ-034 After 033, store byte 0x55 at 0x012, load byte signed 0x013 -> memory word 0xDE55BEEF; rdata=0xFFFFFFDE; lbu 0x012 -> 0x00000055.
REQ-035 Store half 0x8001 at 0x016 over zeroed word, load half signed 0x016 -> rdata=0xFFFF8001; unsigned -> 0x00008001; bytes 0x014/0x015 still 0.
REQ-036 Load word at 0x011, store half at 0x013, size=11 -> ack+misalign at +1, dm_wr never high, rdata unchanged.
REQ-037 req pulsed during RD of an in-flight load -> ignored, exactly one ack; rst_n low during WR -> dm_wr falls immediately, memory unchanged, FSM in IDLE.
